// File: rtl/hamming_dec_engine_pkg.sv
// Shared types and defaults for the SECDED decode engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hamming_dec_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        FLAG_NONE   = 2'b00,
        FLAG_SINGLE = 2'b01,
        FLAG_DOUBLE = 2'b10
    } flag_t;

    localparam int DEF_MSG_COUNT = 15;
    localparam int DEF_SRC_BASE  = 30;
    localparam int DEF_DST_BASE  = 0;

endpackage

// File: rtl/hamming_dec_engine_secded_dec.sv
// Combinational SECDED(16,11) decoder: corrects single errors, flags doubles.
// Latency: 0 cycles.
// Backpressure: none, purely combinational.
module secded_dec
    import hamming_dec_engine_pkg::*;
(
    input  logic [15:0] cw,
    output logic [10:0] data,
    output flag_t       flags
);

    // Hamming positions that carry data bits d1..d11, in order.
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic [3:0] syn;
    logic       par;
    logic       fix;

    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par = ^cw;

        flags = FLAG_NONE;
        if (par) begin
            flags = FLAG_SINGLE;
        end else if (syn != 4'd0) begin
            flags = FLAG_DOUBLE;
        end

        // A zero syndrome with odd parity means only p0 flipped: nothing to repair.
        fix  = par && (syn != 4'd0);
        data = '0;
        for (int j = 0; j < 11; j++) begin
            data[j] = cw[DPOS[j]] ^ (fix && (syn == 4'(DPOS[j])));
        end
    end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-to-memory SECDED decode engine: reads MSG_COUNT codewords, writes decoded words.
// Latency: 4 cycles per word; done rises 4*MSG_COUNT+1 cycles after start.
// Backpressure: none; memory is assumed zero-wait, start is ignored while busy.
module hamming_dec_engine
    import hamming_dec_engine_pkg::*;
#(
    parameter int MSG_COUNT = DEF_MSG_COUNT,
    parameter int SRC_BASE  = DEF_SRC_BASE,
    parameter int DST_BASE  = DEF_DST_BASE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] single_cnt,
    output logic [3:0] double_cnt
);

    state_t      state;
    state_t      nstate;
    logic [7:0]  idx;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic        last;
    logic [10:0] dec_data;
    flag_t       dec_flags;
    logic [7:0]  out_lo;
    logic [7:0]  out_hi;

    secded_dec u_dec (
        .cw    ({hi_q, lo_q}),
        .data  (dec_data),
        .flags (dec_flags)
    );

    assign src_addr = 8'(SRC_BASE) + {idx[6:0], 1'b0};
    assign dst_addr = 8'(DST_BASE) + {idx[6:0], 1'b0};
    assign last     = (idx == 8'(MSG_COUNT - 1));
    assign out_lo   = dec_data[7:0];
    assign out_hi   = {dec_flags, 3'b000, dec_data[10:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate      = state;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) nstate = RD_LO;
            end
            RD_LO: begin
                mem_addr = src_addr;
                nstate   = RD_HI;
            end
            RD_HI: begin
                mem_addr = src_addr + 8'd1;
                nstate   = WR_LO;
            end
            // Writes are squashed during reset so an aborted run never lands a byte.
            WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = !reset;
                mem_wr_data = out_lo;
                nstate      = WR_HI;
            end
            WR_HI: begin
                mem_addr    = dst_addr + 8'd1;
                mem_wr_en   = !reset;
                mem_wr_data = out_hi;
                nstate      = last ? FIN : RD_LO;
            end
            FIN: begin
                done = 1'b1;
                if (start) nstate = RD_LO;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        idx        <= '0;
                        single_cnt <= '0;
                        double_cnt <= '0;
                    end
                end
                RD_LO: lo_q <= mem_rd_data;
                RD_HI: hi_q <= mem_rd_data;
                WR_LO: begin
                    if (dec_flags == FLAG_SINGLE && single_cnt != 4'hF) begin
                        single_cnt <= single_cnt + 4'd1;
                    end
                    if (dec_flags == FLAG_DOUBLE && double_cnt != 4'hF) begin
                        double_cnt <= double_cnt + 4'd1;
                    end
                end
                WR_HI: begin
                    if (!last) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Randomized bench for hamming_dec_engine against a behavioural SECDED model.
// A negedge monitor checks every memory write against an expected-write queue.
module tb_hamming_dec_engine;

    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] single_cnt;
    logic [3:0] double_cnt;

    logic [7:0] mem [256];
    int         wr_count = 0;
    int         nchk = 0;
    int         nerr = 0;
    logic [15:0] exp_q [$];   // {addr, data}
    int         exp_single;
    int         exp_double;

    always #5 clk = ~clk;

    hamming_dec_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .single_cnt  (single_cnt),
        .double_cnt  (double_cnt)
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_data_pos(input int k);
        return (k >= 3) && ((k & (k - 1)) != 0);
    endfunction

    // Build a clean codeword: data in non-power-of-two slots, parity makes syndrome 0, p0 evens the word.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c = '0;
        int j = 0;
        int s = 0;
        for (int k = 3; k < 16; k++) begin
            if (is_data_pos(k)) begin
                c[k] = d[j];
                j++;
            end
        end
        for (int k = 1; k < 16; k++) if (c[k]) s = s ^ k;
        for (int b = 0; b < 4; b++) c[1 << b] = s[b];
        c[0] = ($countones(c) % 2) == 1;
        return c;
    endfunction

    // Returns {flags(2), hi byte, lo byte} per the decoding rules.
    function automatic logic [17:0] ref_decode(input logic [15:0] cw);
        int s = 0;
        int p;
        logic [1:0] fl;
        logic [10:0] d = '0;
        int j = 0;
        logic [15:0] c = cw;
        for (int k = 1; k < 16; k++) if (c[k]) s = s ^ k;
        p = $countones(c) % 2;
        if (s == 0 && p == 0) fl = 2'b00;
        else if (p == 1) begin
            fl = 2'b01;
            if (s != 0) c[s] = ~c[s];
        end else fl = 2'b10;
        for (int k = 3; k < 16; k++) begin
            if (is_data_pos(k)) begin
                d[j] = c[k];
                j++;
            end
        end
        return {fl, fl, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] c = encode(11'($urandom));
        int nflip = $urandom_range(0, 2);
        int a = $urandom_range(0, 15);
        int b = (a + $urandom_range(1, 15)) % 16;
        if (nflip >= 1) c[a] = ~c[a];
        if (nflip == 2) c[b] = ~c[b];
        return c;
    endfunction

    always @(negedge clk) begin
        if (!reset && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                chk("wr_data", {24'd0, mem_wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic load_src(input logic [15:0] w [N]);
        for (int i = 0; i < N; i++) begin
            mem[(SRC + 2 * i) % 256]     = w[i][7:0];
            mem[(SRC + 2 * i + 1) % 256] = w[i][15:8];
        end
        for (int i = 0; i < 2 * N; i++) mem[(DST + i) % 256] = 8'hEE;
    endtask

    task automatic build_expect(input logic [15:0] w [N]);
        logic [17:0] r;
        exp_q.delete();
        exp_single = 0;
        exp_double = 0;
        for (int i = 0; i < N; i++) begin
            r = ref_decode(w[i]);
            exp_q.push_back({8'((DST + 2 * i) % 256), r[7:0]});
            exp_q.push_back({8'((DST + 2 * i + 1) % 256), r[15:8]});
            if (r[17:16] == 2'b01) exp_single++;
            if (r[17:16] == 2'b10) exp_double++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] w [N], input int mid_start);
        int cycles;
        logic [17:0] r;
        load_src(w);
        build_expect(w);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == mid_start);
        end
        start = 1'b0;
        chk({tag, "_done_latency"}, cycles, 4 * N + 1);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        for (int i = 0; i < N; i++) begin
            r = ref_decode(w[i]);
            chk({tag, "_mem_lo"}, {24'd0, mem[(DST + 2 * i) % 256]}, {24'd0, r[7:0]});
            chk({tag, "_mem_hi"}, {24'd0, mem[(DST + 2 * i + 1) % 256]}, {24'd0, r[15:8]});
        end
        chk({tag, "_single_cnt"}, {28'd0, single_cnt}, exp_single);
        chk({tag, "_double_cnt"}, {28'd0, double_cnt}, exp_double);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_done_held"}, {31'd0, done}, 1);
    endtask

    initial begin
        logic [15:0] w [N];
        logic [15:0] dir_cw [4];
        logic [7:0]  dir_hi [4];
        int          dir_s  [4];
        int          dir_d  [4];
        int          wr_before;

        dir_cw = '{16'hFFFF, 16'h0008, 16'h0001, 16'h0003};
        dir_hi = '{8'h07, 8'h40, 8'h40, 8'h80};
        dir_s  = '{0, 1, 1, 0};
        dir_d  = '{0, 0, 0, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;

        // Pin the model itself to hand-computed values.
        chk("model_ffff", ref_decode(16'hFFFF), 18'h007FF);
        chk("model_0008", ref_decode(16'h0008), 18'h14000);
        chk("model_0001", ref_decode(16'h0001), 18'h14000);
        chk("model_0003", ref_decode(16'h0003), 18'h28000);
        chk("model_encode", ref_decode(encode(11'h5A3)), {10'h0, 8'h05, 8'hA3} & 18'h0FFFF);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_wr_data", {24'd0, mem_wr_data}, 0);
        chk("rst_single", {28'd0, single_cnt}, 0);
        chk("rst_double", {28'd0, double_cnt}, 0);
        #4 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed: the interesting codeword in slot 0, clean zero words elsewhere.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) w[i] = 16'h0000;
            w[0] = dir_cw[t];
            run_and_check($sformatf("dir%0d", t), w, 0);
            chk($sformatf("dir%0d_core1", t), {24'd0, mem[DST + 1]}, {24'd0, dir_hi[t]});
            chk($sformatf("dir%0d_core0", t), {24'd0, mem[DST]}, {24'd0, (t == 0) ? 8'hFF : 8'h00});
            chk($sformatf("dir%0d_scnt", t), {28'd0, single_cnt}, dir_s[t]);
            chk($sformatf("dir%0d_dcnt", t), {28'd0, double_cnt}, dir_d[t]);
        end

        // Random runs; a stray start pulse mid-run must be ignored.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) w[i] = rand_word();
            run_and_check($sformatf("rnd%0d", r), w, (r == 1) ? 10 : 0);
        end

        // Reset in the middle of a run.
        for (int i = 0; i < N; i++) w[i] = rand_word();
        load_src(w);
        build_expect(w);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        wr_before = wr_count;
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("midrst_addr", {24'd0, mem_addr}, 0);
        chk("midrst_single", {28'd0, single_cnt}, 0);
        chk("midrst_double", {28'd0, double_cnt}, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_writes", wr_count, wr_before);
        chk("midrst_no_resume", {31'd0, done}, 0);

        for (int i = 0; i < N; i++) w[i] = rand_word();
        run_and_check("post_rst", w, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
